mips_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers of the MIPS core.
- Replaces the single-cycle combinational mult/div path and HI/LO file with a multi-cycle datapath: one start/busy/done handshake and stall-friendly timing.
- Sits beside the ALU. The core's decoder issues ops and stalls on `busy` before MFHI/MFLO or a new mult/div.

---
 rtl/mips_muldiv_pkg.sv | 30 +++
 rtl/mips_muldiv_unit_div_iter.sv | 3 +
 rtl/mips_div_iter.sv | 25 ++
 rtl/mips_muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared op codes and FSM state encoding for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [2:0] OpcMult  = 3'd0;
  localparam logic [2:0] OpcMultu = 3'd1;
  localparam logic [2:0] OpcDiv   = 3'd2;
  localparam logic [2:0] OpcDivu  = 3'd3;
  localparam logic [2:0] OpcMthi  = 3'd4;
  localparam logic [2:0] OpcMtlo  = 3'd5;
  localparam logic [2:0] OpcMadd  = 3'd6;
  localparam logic [2:0] OpcMsub  = 3'd7;

  typedef enum logic [2:0] {
    OpMult  = OpcMult,
    OpMultu = OpcMultu,
    OpDiv   = OpcDiv,
    OpDivu  = OpcDivu,
    OpMthi  = OpcMthi,
    OpMtlo  = OpcMtlo,
    OpMadd  = OpcMadd,
    OpMsub  = OpcMsub
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_unit_div_iter.sv
// Empty package; the division step itself is implemented in mips_div_iter.sv.
package mips_muldiv_unit_div_iter_pkg;
endpackage

// File: rtl/mips_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and shift the resulting quotient bit in.
module mips_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_MADD_EN to add MADD (op 6)
// and MSUB (op 7); otherwise those codes are ignored like any other undefined op.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned SW   = WIDTH + MUL_BITS;

  if ((WIDTH % MUL_BITS) != 0) begin : gen_bad_cfg
    $error("MUL_BITS must divide WIDTH exactly");
  end

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d, done_q, done_d;

  // Multiply: prod_q = {partial sum, unconsumed multiplier bits}; divide: {remainder, quotient}.
  logic [SW-1:0]    mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH-1:0] div_rem_next, div_quo_next;

  mips_div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .rem      (prod_q[PW-1:WIDTH]),
    .quo      (prod_q[WIDTH-1:0]),
    .divisor  (b_q),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  always_comb begin
    mul_sum  = SW'(a_q) * SW'(prod_q[MUL_BITS-1:0]) + SW'(prod_q[PW-1:WIDTH]);
    mul_next = PW'({mul_sum, prod_q[WIDTH-1:0]} >> MUL_BITS);
  end

  logic             acc_op, acc_div, op_signed, q_is_div;
  logic [WIDTH-1:0] a_abs, b_abs, quo_s, rem_s, a_raw;
  logic [PW-1:0]    prod_s;
  muldiv_op_t       op_in;

  always_comb begin
    op_in     = muldiv_op_t'(op);
    acc_op    = 1'b0;
    acc_div   = 1'b0;
    op_signed = 1'b0;
    case (op_in)
      OpMult:  begin acc_op = 1'b1; op_signed = 1'b1; end
      OpMultu: acc_op = 1'b1;
      OpDiv:   begin acc_op = 1'b1; acc_div = 1'b1; op_signed = 1'b1; end
      OpDivu:  begin acc_op = 1'b1; acc_div = 1'b1; end
`ifdef MULDIV_MADD_EN
      OpMadd, OpMsub: begin acc_op = 1'b1; op_signed = 1'b1; end
`endif
      default: ;
    endcase
    a_abs = (op_signed && a[WIDTH-1]) ? -a : a;
    b_abs = (op_signed && b[WIDTH-1]) ? -b : b;

    q_is_div = (op_q == OpDiv) || (op_q == OpDivu);
    prod_s   = neg_q ? -prod_q : prod_q;
    quo_s    = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_s    = rem_neg_q ? -prod_q[PW-1:WIDTH] : prod_q[PW-1:WIDTH];
    // The dividend sign flag lets the raw operand be rebuilt for the divide-by-zero result.
    a_raw    = rem_neg_q ? -a_q : a_q;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && acc_op) begin
          op_d      = op_in;
          a_d       = a_abs;
          b_d       = b_abs;
          neg_d     = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d = op_signed & a[WIDTH-1];
          div0_d    = (b == '0);
          cnt_d     = acc_div ? CntW'(WIDTH) : CntW'(WIDTH / MUL_BITS);
          prod_d    = acc_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          state_d   = StRun;
        end else if (start && op_in == OpMthi) begin
          hi_d = a;
        end else if (start && op_in == OpMtlo) begin
          lo_d = a;
        end
      end
      StRun: begin
        prod_d = q_is_div ? {div_rem_next, div_quo_next} : mul_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (q_is_div) begin
          lo_d = div0_q ? {WIDTH{1'b1}} : quo_s;
          hi_d = div0_q ? a_raw : rem_s;
        end else begin
`ifdef MULDIV_MADD_EN
          if (op_q == OpMadd)      {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          else if (op_q == OpMsub) {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
          else                     {hi_d, lo_d} = prod_s;
`else
          {hi_d, lo_d} = prod_s;
`endif
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpMult;
      cnt_q     <= '0;
      prod_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: a radix-2 instance plus a MUL_BITS=4 instance.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic        start, start4;
  logic [2:0]  op, op4;
  logic [31:0] a, b, a4, b4;
  logic        busy, done, busy4, done4;
  logic [31:0] hi, lo, hi4, lo4;

  int total = 0;
  int bad   = 0;
  int e, bc;

  mips_muldiv_unit #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  mips_muldiv_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start4),
    .op         (op4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .hi         (hi4),
    .lo         (lo4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // edge_no counts enabled or not edges since the accept edge (which is edge 1).
  task automatic wait_done(input int first, output int edge_no, output int busy_cyc);
    edge_no  = first;
    busy_cyc = 0;
    while (done !== 1'b1 && edge_no < first + 200) begin
      if (busy === 1'b1) busy_cyc++;
      step();
      edge_no++;
    end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1;
    start = 1'b0; op = 3'd0; a = '0; b = '0;
    start4 = 1'b0; op4 = 3'd0; a4 = '0; b4 = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b0;

    issue(OpcMult, 32'hFFFF_FFFF, 32'd2);
    wait_done(1, e, bc);
    check("mult_edges", 32'(e), 32'd34);
    check("mult_busy_cycles", 32'(bc), 32'd33);
    check("mult_busy_at_done", 32'(busy), 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    // Issued in the done cycle: must be accepted.
    issue(OpcMultu, 32'hFFFF_FFFF, 32'd2);
    check("done_pulse_end", 32'(done), 32'd0);
    check("multu_accepted", 32'(busy), 32'd1);
    wait_done(1, e, bc);
    check("multu_edges", 32'(e), 32'd34);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(OpcDiv, 32'hFFFF_FFF9, 32'd2);
    step();
    issue(OpcMtlo, 32'h0000_DEAD, 32'd0);
    check("mtlo_ignored", lo, 32'hFFFF_FFFE);
    wait_done(3, e, bc);
    check("div_edges", 32'(e), 32'd34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(OpcDivu, 32'd7, 32'd0);
    wait_done(1, e, bc);
    check("div0_edges", 32'(e), 32'd34);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd7);

    issue(OpcDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, e, bc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    issue(OpcMthi, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo_kept", lo, 32'h8000_0000);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_done", 32'(done), 32'd0);

    // 100 / -7 = -14 rem 2, with five frozen edges in the middle.
    issue(OpcDiv, 32'd100, 32'hFFFF_FFF9);
    step();
    step();
    clk_enable = 1'b0;
    repeat (5) step();
    check("freeze_busy", 32'(busy), 32'd1);
    clk_enable = 1'b1;
    wait_done(8, e, bc);
    check("freeze_edges", 32'(e), 32'd39);
    check("freeze_lo", lo, 32'hFFFF_FFF2);
    check("freeze_hi", hi, 32'd2);

`ifdef MULDIV_MADD_EN
    issue(OpcMthi, 32'd0, 32'd0);
    issue(OpcMtlo, 32'd5, 32'd0);
    issue(OpcMadd, 32'd3, 32'hFFFF_FFFE);
    wait_done(1, e, bc);
    check("madd_edges", 32'(e), 32'd34);
    check("madd_hi", hi, 32'hFFFF_FFFF);
    check("madd_lo", lo, 32'hFFFF_FFFF);
`else
    issue(OpcMadd, 32'd3, 32'hFFFF_FFFE);
    check("op6_busy", 32'(busy), 32'd0);
    step();
    check("op6_done", 32'(done), 32'd0);
    check("op6_hi_kept", hi, 32'd2);
`endif

    issue(OpcMult, 32'd5, 32'd7);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_done", 32'(done), 32'd0);
    bc = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) bc++;
    end
    check("abort_no_done", 32'(bc), 32'd0);
    check("abort_lo_later", lo, 32'h0);

    op4 = OpcMultu; a4 = 32'h0000_FFFF; b4 = 32'h0000_FFFF; start4 = 1'b1;
    step();
    start4 = 1'b0;
    e = 1;
    while (done4 !== 1'b1 && e < 100) begin
      step();
      e++;
    end
    check("r16_edges", 32'(e), 32'd10);
    check("r16_lo", lo4, 32'hFFFE_0001);
    check("r16_hi", hi4, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
